// File: rtl/avalon_burst_arbiter.sv
// N-host Avalon-MM burst arbiter in front of one SDRAM agent: one fixed-priority host,
// round-robin among the rest, grant held for a whole read or write burst.
module avalon_burst_arbiter #(
  parameter int unsigned NH        = 3,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned BCW       = 5,
  parameter int unsigned PRIO_HOST = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NH*AW-1:0]       h_address,
  input  logic [NH-1:0]          h_read,
  input  logic [NH-1:0]          h_write,
  input  logic [NH*DW-1:0]       h_writedata,
  input  logic [NH*(DW/8)-1:0]   h_byteenable,
  input  logic [NH*BCW-1:0]      h_burstcount,
  output logic [NH-1:0]          h_waitrequest,
  output logic [DW-1:0]          h_readdata,
  output logic [NH-1:0]          h_readdatavalid,
  output logic [AW-1:0]          m_address,
  output logic [DW-1:0]          m_writedata,
  output logic [DW/8-1:0]        m_byteenable,
  output logic [BCW-1:0]         m_burstcount,
  output logic                   m_read,
  output logic                   m_write,
  input  logic                   m_waitrequest,
  input  logic [DW-1:0]          m_readdata,
  input  logic                   m_readdatavalid,
  output logic [NH-1:0]          grant,
  output logic                   err_stray
);

  localparam int unsigned IW  = (NH > 1) ? $clog2(NH) : 1;
  localparam int unsigned BEW = DW / 8;
  localparam int unsigned FirstNp = (PRIO_HOST == 0) ? 1 : 0;
  localparam logic [IW-1:0] RrReset = (FirstNp == 0) ? IW'(NH - 1) : IW'(FirstNp - 1);

  typedef enum logic [1:0] {StIdle, StWrBurst, StRdCmd, StRdData} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  gidx_q, gidx_d;
  logic [IW-1:0]  rr_q, rr_d;
  logic [BCW-1:0] len_q, len_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic           err_stray_q;

  logic [NH-1:0]  req;
  logic [IW-1:0]  win_idx;
  logic [IW-1:0]  cand;
  logic           found;
  logic [BCW-1:0] win_bc;
  logic           g_read, g_write;

  assign req     = h_read | h_write;
  assign g_read  = h_read[gidx_q];
  assign g_write = h_write[gidx_q];
  assign win_bc  = h_burstcount[win_idx*BCW +: BCW];

  // Priority host first; otherwise scan forward from the last non-priority winner.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    if (req[PRIO_HOST]) begin
      win_idx = IW'(PRIO_HOST);
      found   = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= NH; k++) begin
        cand = IW'((32'(rr_q) + k) % NH);
        if (!found && cand != IW'(PRIO_HOST) && req[cand]) begin
          win_idx = cand;
          found   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    rr_d       = rr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gidx_d     = win_idx;
          len_d      = (win_bc == '0) ? BCW'(1) : win_bc;
          beat_cnt_d = '0;
          if (win_idx != IW'(PRIO_HOST)) rr_d = win_idx;
          state_d    = h_read[win_idx] ? StRdCmd : StWrBurst;
        end
      end
      StWrBurst: begin
        if (g_write && !m_waitrequest) begin
          beat_cnt_d = beat_cnt_q + BCW'(1);
          if (beat_cnt_q == len_q - BCW'(1)) state_d = StIdle;
        end
      end
      StRdCmd: begin
        if (g_read && !m_waitrequest) begin
          beat_cnt_d = '0;
          state_d    = StRdData;
        end
      end
      StRdData: begin
        if (m_readdatavalid) begin
          beat_cnt_d = beat_cnt_q + BCW'(1);
          if (beat_cnt_q == len_q - BCW'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gidx_q      <= '0;
      rr_q        <= RrReset;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      err_stray_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      rr_q       <= rr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      if (m_readdatavalid && state_q != StRdData) err_stray_q <= 1'b1;
    end
  end

  always_comb begin
    h_waitrequest   = '1;
    h_readdatavalid = '0;
    grant           = '0;
    m_read          = 1'b0;
    m_write         = 1'b0;
    if (state_q != StIdle) grant[gidx_q] = 1'b1;
    unique case (state_q)
      StWrBurst: begin
        m_write               = g_write;
        h_waitrequest[gidx_q] = m_waitrequest;
      end
      StRdCmd: begin
        m_read                = g_read;
        h_waitrequest[gidx_q] = m_waitrequest;
      end
      StRdData: h_readdatavalid[gidx_q] = m_readdatavalid;
      default: ;
    endcase
  end

  assign m_address    = h_address[gidx_q*AW +: AW];
  assign m_writedata  = h_writedata[gidx_q*DW +: DW];
  assign m_byteenable = h_byteenable[gidx_q*BEW +: BEW];
  assign m_burstcount = len_q;
  assign h_readdata   = m_readdata;
  assign err_stray    = err_stray_q;

endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// Directed bench for avalon_burst_arbiter: write/read routing, priority, round-robin,
// waitrequest stall and reset during a read burst.
module tb_avalon_burst_arbiter;

  localparam int unsigned NH  = 3;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BCW = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NH*AW-1:0]     h_address;
  logic [NH-1:0]        h_read, h_write;
  logic [NH*DW-1:0]     h_writedata;
  logic [NH*(DW/8)-1:0] h_byteenable;
  logic [NH*BCW-1:0]    h_burstcount;
  logic [NH-1:0]        h_waitrequest;
  logic [DW-1:0]        h_readdata;
  logic [NH-1:0]        h_readdatavalid;
  logic [AW-1:0]        m_address;
  logic [DW-1:0]        m_writedata;
  logic [DW/8-1:0]      m_byteenable;
  logic [BCW-1:0]       m_burstcount;
  logic                 m_read, m_write;
  logic                 m_waitrequest;
  logic [DW-1:0]        m_readdata;
  logic                 m_readdatavalid;
  logic [NH-1:0]        grant;
  logic                 err_stray;

  int n_cmp = 0;
  int n_err = 0;
  logic [NH-1:0] gseq [8];
  int gn;

  avalon_burst_arbiter #(.NH(NH), .AW(AW), .DW(DW), .BCW(BCW), .PRIO_HOST(0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .h_address       (h_address),
    .h_read          (h_read),
    .h_write         (h_write),
    .h_writedata     (h_writedata),
    .h_byteenable    (h_byteenable),
    .h_burstcount    (h_burstcount),
    .h_waitrequest   (h_waitrequest),
    .h_readdata      (h_readdata),
    .h_readdatavalid (h_readdatavalid),
    .m_address       (m_address),
    .m_writedata     (m_writedata),
    .m_byteenable    (m_byteenable),
    .m_burstcount    (m_burstcount),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .grant           (grant),
    .err_stray       (err_stray)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    h_read          = '0;
    h_write         = '0;
    h_address       = '0;
    h_writedata     = '0;
    h_byteenable    = '1;
    h_burstcount    = '0;
    m_waitrequest   = 1'b0;
    m_readdata      = '0;
    m_readdatavalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  // Host h writes a burst; m_waitrequest is held high stall_n cycles while beat stall_at is offered.
  task automatic run_write(input int h, input int bc, input int stall_at, input int stall_n,
                           output int beats, output int cyc);
    int   stall;
    logic acc;
    stall = stall_n;
    beats = 0;
    cyc   = 0;
    h_address[h*AW +: AW]       = 32'h1000 + 32'(h);
    h_burstcount[h*BCW +: BCW]  = BCW'(bc);
    h_writedata[h*DW +: DW]     = 32'hA0;
    h_write[h]                  = 1'b1;
    #1;
    check_eq("wr_wait_pre", 64'(h_waitrequest[h]), 64'd1);
    check_eq("wr_grant_pre", 64'(grant), 64'd0);
    step();
    check_eq("wr_grant", 64'(grant), 64'(1 << h));
    check_eq("wr_addr", 64'(m_address), 64'(32'h1000 + h));
    while (grant != '0 && cyc < 40) begin
      cyc++;
      if (beats == stall_at && stall > 0) begin
        m_waitrequest = 1'b1;
        stall--;
      end else begin
        m_waitrequest = 1'b0;
      end
      #1;
      if (m_waitrequest) begin
        check_eq("wr_hold_wdata", 64'(m_writedata), 64'(32'hA0 + stall_at));
        check_eq("wr_hold_wait", 64'(h_waitrequest[h]), 64'd1);
      end
      acc = m_write && !m_waitrequest;
      step();
      if (acc) begin
        beats++;
        h_writedata[h*DW +: DW] = 32'hA0 + 32'(beats);
      end
      if (grant == '0) h_write[h] = 1'b0;
      #1;
    end
    h_write[h]    = 1'b0;
    m_waitrequest = 1'b0;
    #1;
    check_eq("wr_idle_mwrite", 64'(m_write), 64'd0);
  endtask

  // Hosts 1/2 write continuously; optionally host 0 joins during host 1's second burst cycle.
  task automatic collect(input int n, input bit inject);
    logic [NH-1:0] prev;
    int c1;
    gn   = 0;
    prev = '0;
    c1   = 0;
    h_burstcount[0*BCW +: BCW] = BCW'(2);
    for (int c = 0; c < 80 && gn < n; c++) begin
      step();
      if (grant != '0 && prev == '0) begin
        gseq[gn] = grant;
        gn++;
      end
      if (grant == 3'b010) c1++;
      if (inject && c1 == 2 && grant == 3'b010) h_write[0] = 1'b1;
      if (grant == '0 && prev == 3'b001) h_write[0] = 1'b0;
      prev = grant;
    end
    check_eq("rr_count", 64'(gn), 64'(n));
  endtask

  initial begin
    int beats, cyc, hv0, hvx;

    // Reset values
    do_reset();
    check_eq("rst_grant", 64'(grant), 64'd0);
    check_eq("rst_wait", 64'(h_waitrequest), 64'b111);
    check_eq("rst_rdv", 64'(h_readdatavalid), 64'd0);
    check_eq("rst_mrw", 64'({m_read, m_write}), 64'd0);
    check_eq("rst_err", 64'(err_stray), 64'd0);

    // Single-host write, 4 beats, no stall
    run_write(1, 4, 99, 0, beats, cyc);
    check_eq("t1_beats", 64'(beats), 64'd4);
    check_eq("t1_cycles", 64'(cyc), 64'd4);

    // Burstcount 0 treated as a single beat
    do_reset();
    run_write(2, 0, 99, 0, beats, cyc);
    check_eq("bc0_beats", 64'(beats), 64'd1);
    check_eq("bc0_cycles", 64'(cyc), 64'd1);

    // Read routing: host 0, 8 beats after latency
    do_reset();
    h_address[0 +: AW]      = 32'h0000_4000;
    h_burstcount[0 +: BCW]  = BCW'(8);
    h_read[0]               = 1'b1;
    #1;
    step();
    check_eq("t2_grant", 64'(grant), 64'b001);
    check_eq("t2_mread", 64'(m_read), 64'd1);
    check_eq("t2_addr", 64'(m_address), 64'h4000);
    check_eq("t2_mbc", 64'(m_burstcount), 64'd8);
    step();
    h_read[0] = 1'b0;
    #1;
    check_eq("t2_data_wait", 64'(h_waitrequest), 64'b111);
    check_eq("t2_data_mread", 64'(m_read), 64'd0);
    repeat (4) step();
    hv0 = 0;
    hvx = 0;
    for (int i = 0; i < 8; i++) begin
      m_readdatavalid = 1'b1;
      m_readdata      = 32'hD0 + 32'(i);
      #1;
      hv0 += int'(h_readdatavalid[0]);
      hvx += int'(h_readdatavalid[2:1] != 2'b00);
      check_eq("t2_rdata", 64'(h_readdata), 64'(32'hD0 + i));
      step();
    end
    m_readdatavalid = 1'b0;
    #1;
    check_eq("t2_rdv0", 64'(hv0), 64'd8);
    check_eq("t2_rdv_other", 64'(hvx), 64'd0);
    check_eq("t2_idle", 64'(grant), 64'd0);
    check_eq("t2_err", 64'(err_stray), 64'd0);

    // Priority host wins at the first IDLE after host 1's burst, ahead of host 2
    do_reset();
    h_burstcount[1*BCW +: BCW] = BCW'(4);
    h_burstcount[2*BCW +: BCW] = BCW'(4);
    h_write[2:1] = 2'b11;
    collect(3, 1'b1);
    check_eq("prio_g0", 64'(gseq[0]), 64'b010);
    check_eq("prio_g1", 64'(gseq[1]), 64'b001);
    check_eq("prio_g2", 64'(gseq[2]), 64'b100);

    // Round-robin fairness between hosts 1 and 2
    do_reset();
    h_burstcount[1*BCW +: BCW] = BCW'(2);
    h_burstcount[2*BCW +: BCW] = BCW'(2);
    h_write[2:1] = 2'b11;
    collect(4, 1'b0);
    check_eq("rr_g0", 64'(gseq[0]), 64'b010);
    check_eq("rr_g1", 64'(gseq[1]), 64'b100);
    check_eq("rr_g2", 64'(gseq[2]), 64'b010);
    check_eq("rr_g3", 64'(gseq[3]), 64'b100);

    // Waitrequest stall of 3 cycles on beat 2 of a 4-beat write
    do_reset();
    run_write(1, 4, 2, 3, beats, cyc);
    check_eq("t5_beats", 64'(beats), 64'd4);
    check_eq("t5_cycles", 64'(cyc), 64'd7);

    // Reset during RD_DATA, then stray beats
    do_reset();
    h_burstcount[2*BCW +: BCW] = BCW'(4);
    h_read[2] = 1'b1;
    #1;
    step();
    step();
    h_read[2] = 1'b0;
    m_readdatavalid = 1'b1;
    #1;
    check_eq("t6_grant", 64'(grant), 64'b100);
    check_eq("t6_rdv", 64'(h_readdatavalid), 64'b100);
    step();
    m_readdatavalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_grant", 64'(grant), 64'd0);
    check_eq("t6_rst_wait", 64'(h_waitrequest), 64'b111);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_readdatavalid = 1'b1;
      #1;
      check_eq("t6_stray_rdv", 64'(h_readdatavalid), 64'd0);
      step();
    end
    m_readdatavalid = 1'b0;
    #1;
    check_eq("t6_err", 64'(err_stray), 64'd1);
    check_eq("t6_idle", 64'(grant), 64'd0);
    repeat (2) step();
    check_eq("t6_err_sticky", 64'(err_stray), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
